// File: rtl/draw_board_control_if.sv
// Board-draw control bundle: frame handshake, board memory read port and datapath controls.
interface draw_board_control_if;
  logic       start;
  logic [5:0] board_data;
  logic [5:0] board_addr;
  logic       write;
  logic       update_x_y;
  logic [5:0] draw_value;
  logic       busy;
  logic       done;

  // Control block side.
  modport master (
    input  start,
    input  board_data,
    output board_addr,
    output write,
    output update_x_y,
    output draw_value,
    output busy,
    output done
  );

  // Environment side: requester, board memory and datapath.
  modport slave (
    output start,
    output board_data,
    input  board_addr,
    input  write,
    input  update_x_y,
    input  draw_value,
    input  busy,
    input  done
  );
endinterface

// File: rtl/draw_board_control.sv
// Frame sequencer for the board-drawing datapath: optional background fill, 64 squares, turn mark.
// Define DRAW_BOARD_BG_EN to include the full-screen background phase.
module draw_board_control (
  input  logic                 clk,
  input  logic                 resetn,
  draw_board_control_if.master bus
);

`ifdef DRAW_BOARD_BG_EN
  localparam int unsigned PixW = 15;
  localparam logic [PixW-1:0] PixBgLast = PixW'(32767);
`else
  localparam int unsigned PixW = 8;
`endif
  localparam logic [PixW-1:0] PixSqLast = PixW'(255);
  localparam logic [5:0]      DvBg      = 6'b011000;
  localparam logic [5:0]      DvTurn    = 6'b011100;

  typedef enum logic [2:0] {
    StIdle,
`ifdef DRAW_BOARD_BG_EN
    StBg,
`endif
    StFetch,
    StLatch,
    StCell,
    StNext,
    StTurn,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [5:0]      cell_q, cell_d;
  logic [PixW-1:0] pix_q, pix_d;
  logic [5:0]      addr_q, addr_d;
  logic [5:0]      dv_q, dv_d;
  logic            write_q, write_d;
  logic            upd_q, upd_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  always_comb begin
    state_d = state_q;
    cell_d  = cell_q;
    pix_d   = pix_q;
    unique case (state_q)
      StIdle: begin
        cell_d = '0;
        pix_d  = '0;
        if (bus.start) begin
`ifdef DRAW_BOARD_BG_EN
          state_d = StBg;
`else
          state_d = StFetch;
`endif
        end
      end
`ifdef DRAW_BOARD_BG_EN
      StBg: begin
        if (pix_q == PixBgLast) begin
          pix_d   = '0;
          state_d = StFetch;
        end else begin
          pix_d = pix_q + 1'b1;
        end
      end
`endif
      StFetch: state_d = StLatch;
      StLatch: begin
        pix_d   = '0;
        state_d = StCell;
      end
      StCell: begin
        if (pix_q == PixSqLast) begin
          pix_d   = '0;
          state_d = StNext;
        end else begin
          pix_d = pix_q + 1'b1;
        end
      end
      StNext: begin
        // No increment past square 63; the wrap happens only via the idle clear.
        if (cell_q == 6'd63) begin
          pix_d   = '0;
          state_d = StTurn;
        end else begin
          cell_d  = cell_q + 1'b1;
          state_d = StFetch;
        end
      end
      StTurn: begin
        if (pix_q == PixSqLast) begin
          pix_d   = '0;
          state_d = StDone;
        end else begin
          pix_d = pix_q + 1'b1;
        end
      end
      StDone: begin
        cell_d  = '0;
        pix_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    write_d = (state_d == StCell) || (state_d == StTurn);
`ifdef DRAW_BOARD_BG_EN
    write_d = write_d || (state_d == StBg);
`endif
    upd_d  = (state_d == StNext);
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
    addr_d = (state_d == StFetch) ? cell_d : addr_q;
    dv_d   = dv_q;
    if (state_q == StLatch) begin
      dv_d = bus.board_data;
    end
`ifdef DRAW_BOARD_BG_EN
    if (state_d == StBg) begin
      dv_d = DvBg;
    end
`endif
    if (state_d == StTurn) begin
      dv_d = DvTurn;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cell_q  <= '0;
      pix_q   <= '0;
      addr_q  <= '0;
      dv_q    <= '0;
      write_q <= 1'b0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cell_q  <= cell_d;
      pix_q   <= pix_d;
      addr_q  <= addr_d;
      dv_q    <= dv_d;
      write_q <= write_d;
      upd_q   <= upd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.board_addr = addr_q;
  assign bus.draw_value = dv_q;
  assign bus.write      = write_q;
  assign bus.update_x_y = upd_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_draw_board_control.sv
// Self-checking bench: per-cycle comparison of a whole frame against a cycle-index model.
module tb_draw_board_control;

`ifdef DRAW_BOARD_BG_EN
  localparam int BgLen = 32768;
`else
  localparam int BgLen = 0;
`endif
  localparam int SqLen     = 259;
  localparam int TurnStart = BgLen + 64 * SqLen;
  localparam int FrameLen  = TurnStart + 256 + 1;
  localparam int WrLen     = BgLen + 64 * 256 + 256;

  logic clk;
  logic resetn;
  logic [5:0] mem [64];

  int checks = 0;
  int errors = 0;

  draw_board_control_if bus ();

  draw_board_control u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board memory with one cycle of read latency.
  always @(posedge clk) bus.board_data <= mem[bus.board_addr];

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Expected outputs at cycle t, counted from the first busy cycle of a frame.
  task automatic model(input int t, output bit b, output bit w, output bit u, output bit d,
                       output logic [5:0] dv, output bit dvc, output logic [5:0] ad,
                       output bit ac);
    int x, sq, ph;
    b = 0; w = 0; u = 0; d = 0; dv = '0; dvc = 0; ad = '0; ac = 0;
    if (t < BgLen) begin
      b = 1; w = 1; dv = 6'b011000; dvc = 1;
    end else if (t < TurnStart) begin
      x  = t - BgLen;
      sq = x / SqLen;
      ph = x % SqLen;
      b  = 1;
      if (ph == 0) begin
        ad = 6'(sq); ac = 1;
      end else if (ph >= 2 && ph <= 257) begin
        w = 1; dv = mem[sq]; dvc = 1;
      end else if (ph == 258) begin
        u = 1;
      end
    end else if (t < FrameLen - 1) begin
      b = 1; w = 1; dv = 6'b011100; dvc = 1;
    end else if (t == FrameLen - 1) begin
      b = 1; d = 1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_busy"}, bus.busy, 0);
    check_val({tag, "_write"}, bus.write, 0);
    check_val({tag, "_upd"}, bus.update_x_y, 0);
    check_val({tag, "_done"}, bus.done, 0);
    check_val({tag, "_dv"}, bus.draw_value, 0);
    check_val({tag, "_addr"}, bus.board_addr, 0);
  endtask

  // Pulses start, then compares every cycle up to max_t; returns at the negedge of cycle max_t.
  task automatic run_frame(input string tag, input int restart_at, input int max_t,
                           input bit full);
    bit e_b, e_w, e_u, e_d, e_dvc, e_ac;
    logic [5:0] e_dv, e_ad, first_dv;
    int bad = 0, busy_n = 0, wr_n = 0, upd_n = 0, done_n = 0, done_t = -1;
    bit seen_wr = 0;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    for (int t = 0; t < max_t; t++) begin
      bus.start = (t == restart_at);
      model(t, e_b, e_w, e_u, e_d, e_dv, e_dvc, e_ad, e_ac);
      if (bus.busy !== e_b || bus.write !== e_w || bus.update_x_y !== e_u ||
          bus.done !== e_d || (e_dvc && bus.draw_value !== e_dv) ||
          (e_ac && bus.board_addr !== e_ad)) begin
        bad++;
      end
      if (bus.busy === 1'b1) busy_n++;
      if (bus.write === 1'b1) begin
        wr_n++;
        if (!seen_wr) begin
          seen_wr  = 1;
          first_dv = bus.draw_value;
        end
      end
      if (bus.update_x_y === 1'b1) upd_n++;
      if (bus.done === 1'b1) begin
        done_n++;
        done_t = t;
      end
      @(negedge clk);
    end
    check_val({tag, "_cycle_errs"}, bad, 0);
    if (full) begin
      check_val({tag, "_busy_len"}, busy_n, FrameLen);
      check_val({tag, "_write_len"}, wr_n, WrLen);
      check_val({tag, "_upd_cnt"}, upd_n, 64);
      check_val({tag, "_done_cnt"}, done_n, 1);
      check_val({tag, "_done_pos"}, done_t, FrameLen - 1);
      check_val({tag, "_first_dv"}, first_dv, (BgLen > 0) ? 6'b011000 : mem[0]);
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < 64; k++) mem[k] = 6'($urandom);
  endtask

  initial begin
    logic [5:0] kk;
    resetn    = 1'b0;
    bus.start = 1'b0;
    for (int k = 0; k < 64; k++) begin
      kk     = 6'(k);
      mem[k] = {kk[0], kk[4:0]};
    end
    repeat (3) @(negedge clk);
    check_reset_vals("init");
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Pattern board; a second start mid-frame must be ignored.
    run_frame("pattern", 1000, FrameLen + 20, 1'b1);

`ifndef DRAW_BOARD_BG_EN
    fill_random();
    run_frame("random", $urandom_range(10, FrameLen - 30), FrameLen + 20, 1'b1);
`endif

    // Abort during square 10, pixel 100.
    fill_random();
    run_frame("abort", -1, BgLen + 10 * SqLen + 2 + 100, 1'b0);
    resetn = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    check_val("post_rst_busy", bus.busy, 0);
    check_val("post_rst_write", bus.write, 0);

`ifdef DRAW_BOARD_BG_EN
    run_frame("after_rst", -1, 1000, 1'b0);
`else
    fill_random();
    run_frame("after_rst", -1, FrameLen + 20, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
